// File: rtl/circuit_test_pkg.sv
// Shared types and constants for the 3-input circuit vector checker.
package circuit_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned NUM_STEPS = 8;

    // {in1,in2,in3} applied at each sequence step.
    localparam logic [2:0] VEC_ORDER [NUM_STEPS] = '{
        3'b000, 3'b001, 3'b010, 3'b100,
        3'b011, 3'b110, 3'b101, 3'b111
    };

endpackage

// File: rtl/settle_timer.sv
// Settle-window counter: counts while enabled, wraps to zero at SETTLE_CYCLES-1
// and flags that cycle as the window-end.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 7
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] count_q, count_d;

    assign tc_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr_i || tc_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/circuit_vector_checker.sv
// Drives the fixed 8-vector sequence into a 3-input circuit, samples out1 at the
// end of each settle window and compares against the EXPECTED truth table.
module circuit_vector_checker
    import circuit_test_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 7,
    parameter logic [7:0]  EXPECTED      = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out1,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [2:0] vec_idx,
    output logic [7:0] result,
    output logic [7:0] mismatch,
    output logic       pass
);

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    state_e     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [7:0] result_q, result_d;
    logic [7:0] mismatch_q, mismatch_d;
    logic       pass_q, pass_d;
    logic [2:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tc;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q != ST_RUN),
        .en_i  (state_q == ST_RUN),
        .tc_o  (tc)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        result_d   = result_q;
        mismatch_d = mismatch_q;
        pass_d     = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    k_d        = '0;
                    result_d   = '0;
                    mismatch_d = '0;
                    pass_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (tc) begin
                    result_d[k_q]   = out1;
                    mismatch_d[k_q] = out1 ^ EXPECTED[k_q];
                    if (k_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        k_d     = '0;
                        // Uses the word including the bit written this cycle.
                        pass_d  = ~|mismatch_d;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        stim_d = (state_d == ST_RUN) ? VEC_ORDER[k_d] : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            result_q   <= '0;
            mismatch_q <= '0;
            pass_q     <= 1'b0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            result_q   <= result_d;
            mismatch_q <= mismatch_d;
            pass_q     <= pass_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign {in1, in2, in3} = stim_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign vec_idx         = k_q;
    assign result          = result_q;
    assign mismatch        = mismatch_q;
    assign pass            = pass_q;

endmodule
